// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types, key map and column helpers for the hex keypad scanner.
//   kp_state_t : scanner FSM states
//   KEYMAP     : (row, column index) -> hex key code
//   col_index  : one-hot active-low column drive -> column index
//   rotate_col : next column in the scan order 1110 -> 1101 -> 1011 -> 0111
package hex_keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2
    } kp_state_t;

    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   i_clk   : destination clock
//   i_rst   : asynchronous active-high reset, clears both stages to all ones
//   i_async : asynchronous input bus
//   o_sync  : synchronized output, two cycles behind i_async
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with debounce and a 4-digit key history register.
//   i_clk        : system clock
//   i_rst        : asynchronous active-high reset
//   i_row        : keypad rows, active-low, asynchronous
//   o_col        : column drive, one-hot active-low
//   o_key_code   : last accepted key
//   o_key_valid  : one-cycle pulse on key acceptance
//   o_key_held   : high from acceptance until the release is debounced
//   o_data       : last four accepted keys, newest in [3:0]
module hex_keypad_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_held,
    output logic [15:0] o_data
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // Acceptance happens on the tick that would bring a counter to DEBOUNCE_SCANS.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       w_rs;
    logic             w_tick;
    logic             w_row_hit;
    logic [1:0]       w_row_idx;
    logic [3:0]       w_code;

    logic [DIV_W-1:0] r_div_cnt;
    kp_state_t        r_state;
    logic [3:0]       r_col;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_rel_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic [15:0]      r_data;

    sync2 #(
        .WIDTH (4)
    ) u_row_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_row),
        .o_sync  (w_rs)
    );

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Iterate high to low so the lowest low row is the final assignment.
    always_comb begin
        w_row_hit = 1'b0;
        w_row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!w_rs[r]) begin
                w_row_hit = 1'b1;
                w_row_idx = 2'(r);
            end
        end
    end

    assign w_code = KEYMAP[w_row_idx][col_index(r_col)];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= SCAN;
            r_col       <= 4'b1110;
            r_cand      <= 4'h0;
            r_match_cnt <= '0;
            r_rel_cnt   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_data      <= 16'h0000;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    SCAN: begin
                        if (!w_row_hit) begin
                            r_col <= rotate_col(r_col);
                        end else begin
                            r_cand      <= w_code;
                            r_match_cnt <= CNT_W'(1);
                            r_state     <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (w_row_hit && (w_code == r_cand)) begin
                            if (r_match_cnt >= CNT_LAST) begin
                                r_match_cnt <= '0;
                                r_rel_cnt   <= '0;
                                r_key_code  <= r_cand;
                                r_data      <= {r_data[11:0], r_cand};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                                r_state     <= PRESSED;
                            end else begin
                                r_match_cnt <= r_match_cnt + CNT_W'(1);
                            end
                        end else begin
                            // Sample disagreed: treat as a glitch and move on.
                            r_match_cnt <= '0;
                            r_col       <= rotate_col(r_col);
                            r_state     <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (!w_row_hit) begin
                            if (r_rel_cnt >= CNT_LAST) begin
                                r_rel_cnt  <= '0;
                                r_key_held <= 1'b0;
                                r_col      <= rotate_col(r_col);
                                r_state    <= SCAN;
                            end else begin
                                r_rel_cnt <= r_rel_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_rel_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign o_col       = r_col;
    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;
    assign o_data      = r_data;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: keypad model, scoreboard of expected key acceptances.
module tb_hex_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] data;
    logic [15:0] keys = '0;   // bit r*4+c = key (r,c) pressed

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int tb_div   = 0;

    logic [19:0] sb_q[$];      // {code, data} expected per acceptance
    logic [15:0] model_data = '0;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_row       (row),
        .o_col       (col),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held),
        .o_data      (data)
    );

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    // Reference phase of the column period, used only to time stimulus.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_div <= 0;
        else     tb_div <= (tb_div == SCAN_DIV - 1) ? 0 : tb_div + 1;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            logic [19:0] e;
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_valid", 16'(sb_q.size()), 16'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_key_code", {12'h0, key_code}, {12'h0, e[19:16]});
                check_eq("sb_data", data, e[15:0]);
            end
        end
    end

    function automatic logic [3:0] key_of(input int r, input int c);
        case (r * 4 + c)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8;  10: return 4'h9; 11: return 4'hC;
            12: return 4'h0; 13: return 4'hF; 14: return 4'hE; default: return 4'hD;
        endcase
    endfunction

    task automatic press(input int r, input int c);
        logic [3:0] k;
        int exp_cnt;
        k = key_of(r, c);
        model_data = {model_data[11:0], k};
        sb_q.push_back({k, model_data});
        exp_cnt = pulse_cnt + 1;
        keys[r*4+c] = 1'b1;
        for (int i = 0; i < 100 && pulse_cnt != exp_cnt; i++) @(negedge clk);
        check_eq("press_seen", 16'(pulse_cnt), 16'(exp_cnt));
        check_eq("held_after_press", {15'h0, key_held}, 16'd1);
    endtask

    task automatic release_all(output int n);
        keys = '0;
        n = 0;
        while (key_held && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("release_done", {15'h0, key_held}, 16'd0);
    endtask

    task automatic wait_col(input logic [3:0] c);
        for (int i = 0; i < 64 && col == c; i++) @(negedge clk);
        for (int i = 0; i < 64 && col != c; i++) @(negedge clk);
        check_eq("wait_col", {12'h0, col}, {12'h0, c});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_col"}, {12'h0, col}, 16'h000E);
        check_eq({tag, "_code"}, {12'h0, key_code}, 16'h0000);
        check_eq({tag, "_valid"}, {15'h0, key_valid}, 16'd0);
        check_eq({tag, "_held"}, {15'h0, key_held}, 16'd0);
        check_eq({tag, "_data"}, data, 16'h0000);
    endtask

    initial begin
        logic [3:0] walk [0:4];
        int n;
        int start;
        walk[0] = 4'b1101; walk[1] = 4'b1011; walk[2] = 4'b0111;
        walk[3] = 4'b1110; walk[4] = 4'b1101;

        // 1. reset and column walk
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            repeat (3) @(negedge clk);
            check_eq("col_hold", {12'h0, col}, {12'h0, (s == 0) ? 4'b1110 : walk[s-1]});
            @(negedge clk);
            check_eq("col_walk", {12'h0, col}, {12'h0, walk[s]});
        end

        // 2. single clean key '6', release latency, scanning resumes
        press(1, 2);
        release_all(n);
        check_eq("release_latency", 16'(n >= 11 && n <= 14), 16'd1);
        check_eq("col_after_release", {12'h0, col}, 16'h0007);
        repeat (4) @(negedge clk);
        check_eq("scan_resumed", {12'h0, col}, 16'h000E);

        // 3. key sequence into the history register
        start = pulse_cnt;
        press(0, 0); release_all(n);
        press(0, 1); release_all(n);
        press(0, 2); release_all(n);
        press(0, 3); release_all(n);
        check_eq("data_123A", data, 16'h123A);
        press(1, 1); release_all(n);
        check_eq("data_23A5", data, 16'h23A5);
        check_eq("five_pulses", 16'(pulse_cnt - start), 16'd5);

        // 4a. one-tick glitch on '9' is rejected and scanning advances
        start = pulse_cnt;
        wait_col(4'b1011);
        keys[10] = 1'b1;
        repeat (4) @(negedge clk);
        keys[10] = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("glitch_col_adv", {12'h0, col}, 16'h0007);
        check_eq("glitch_no_held", {15'h0, key_held}, 16'd0);
        check_eq("glitch_no_valid", 16'(pulse_cnt - start), 16'd0);

        // 4b. release bounce restarts the release count
        press(2, 2);
        do @(negedge clk); while (tb_div != 0);
        keys[10] = 1'b0;
        repeat (8) @(negedge clk);
        keys[10] = 1'b1;
        repeat (4) @(negedge clk);
        keys[10] = 1'b0;
        check_eq("bounce_held0", {15'h0, key_held}, 16'd1);
        repeat (11) @(negedge clk);
        check_eq("bounce_held_hold", {15'h0, key_held}, 16'd1);
        @(negedge clk);
        check_eq("bounce_held_drop", {15'h0, key_held}, 16'd0);

        // 5. two keys in one column: lowest row wins; extra key while held ignored
        keys[8] = 1'b1;
        press(1, 0);
        start = pulse_cnt;
        keys[14] = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("no_second_valid", 16'(pulse_cnt - start), 16'd0);
        check_eq("still_held", {15'h0, key_held}, 16'd1);
        check_eq("multi_code", {12'h0, key_code}, 16'h0004);
        release_all(n);

        // 6a. reset while confirming
        wait_col(4'b1110);
        keys[0] = 1'b1;
        repeat (6) @(negedge clk);
        start = pulse_cnt;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_confirm");
        model_data = '0;
        repeat (3) @(negedge clk);
        keys = '0;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("confirm_rst_no_valid", 16'(pulse_cnt - start), 16'd0);

        // 6b. reset while pressed
        press(0, 3);
        check_eq("pre_rst_data", data, 16'h000A);
        repeat (5) @(negedge clk);
        start = pulse_cnt;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_pressed");
        model_data = '0;
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("pressed_rst_no_valid", 16'(pulse_cnt - start), 16'd0);

        check_eq("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
